// File: rtl/activation_stream.sv
// -----------------------------------------------------------------------------
// activation_stream
//   Pipelined activation unit with a valid/ready handshake. Each beat carries
//   MATRIX_WIDTH fixed-point lanes plus its own mode and signedness. One of five
//   functions (NONE, RELU, RELU6, LEAKY, HSIG) is applied per lane, and the
//   result is quantised to OUT_WIDTH bits.
//
//   Pipeline: S1 capture -> S2 function -> S3 quantise -> output register.
//   All stages shift together whenever the output register is empty or being
//   drained. A beat accepted at edge N appears on the output after edge N+3.
//
// Ports
//   clk_i        clock
//   rst_i        synchronous, active-high reset
//   in_valid_i   input beat valid
//   in_ready_o   unit accepts a beat this cycle
//   mode_i       0 NONE, 1 RELU, 2 RELU6, 3 LEAKY, 4 HSIG, 5-7 NONE
//   is_signed_i  1: lanes are two's complement, 0: lanes are unsigned
//   data_in_i    lane i at [i*IN_WIDTH +: IN_WIDTH]
//   out_valid_o  output beat valid
//   out_ready_i  consumer accepts the output beat
//   data_out_o   lane i at [i*OUT_WIDTH +: OUT_WIDTH]
//   sat_count_o  saturated-lane counter       (ACT_SAT_COUNT_EN only)
//   sat_clear_i  clears sat_count_o            (ACT_SAT_COUNT_EN only)
//
// Build option
//   ACT_SAT_COUNT_EN : adds the saturation counter and its two ports.
// -----------------------------------------------------------------------------
module activation_stream #(
  parameter int MATRIX_WIDTH  = 4,
  parameter int IN_WIDTH      = 32,
  parameter int FRAC_BITS     = 16,
  parameter int OUT_WIDTH     = 8,
  parameter int OUT_FRAC_BITS = 0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [2:0]                        mode_i,
  input  logic                              is_signed_i,
  input  logic [MATRIX_WIDTH*IN_WIDTH-1:0]  data_in_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [MATRIX_WIDTH*OUT_WIDTH-1:0] data_out_o
`ifdef ACT_SAT_COUNT_EN
  ,
  output logic [31:0]                       sat_count_o,
  input  logic                              sat_clear_i
`endif
);

  // S2 carries four extra headroom bits so RELU6/HSIG arithmetic cannot wrap.
  localparam int W2 = IN_WIDTH + 4;
  // HSIG scales by 2^OUT_WIDTH before dropping the fraction.
  localparam int QW = W2 + OUT_WIDTH;
  localparam int SH = FRAC_BITS - OUT_FRAC_BITS;

  typedef logic signed [W2-1:0] wide_t;
  typedef logic signed [QW-1:0] qwide_t;

  localparam logic [2:0] MODE_NONE  = 3'd0;
  localparam logic [2:0] MODE_RELU  = 3'd1;
  localparam logic [2:0] MODE_RELU6 = 3'd2;
  localparam logic [2:0] MODE_LEAKY = 3'd3;
  localparam logic [2:0] MODE_HSIG  = 3'd4;

  localparam wide_t  ONE_W  = wide_t'(1) <<< FRAC_BITS;
  localparam wide_t  HALF_W = ONE_W >>> 1;
  localparam wide_t  SIX_W  = wide_t'(6) <<< FRAC_BITS;
  localparam wide_t  SMAX   = wide_t'((1 << (OUT_WIDTH - 1)) - 1);
  localparam wide_t  SMIN   = -SMAX - wide_t'(1);
  localparam wide_t  UMAX   = wide_t'((1 << OUT_WIDTH) - 1);
  localparam qwide_t UMAX_Q = qwide_t'(UMAX);

  // ---------------------------------------------------------------------------
  // Lane helpers
  // ---------------------------------------------------------------------------
  function automatic wide_t extend(input logic [IN_WIDTH-1:0] lane, input logic sgn);
    logic ext;
    ext = sgn & lane[IN_WIDTH-1];
    return wide_t'({{4{ext}}, lane});
  endfunction

  // Unsigned lanes are zero-extended, so they are never negative and
  // RELU/LEAKY naturally collapse to NONE for them.
  function automatic wide_t act_fn(input wide_t x, input logic [2:0] mode);
    wide_t y;
    wide_t h;
    y = x;
    h = (x >>> 2) + HALF_W;
    case (mode)
      MODE_RELU: begin
        if (x < 0) y = '0;
      end
      MODE_RELU6: begin
        if (x < 0)          y = '0;
        else if (x > SIX_W) y = SIX_W;
      end
      MODE_LEAKY: begin
        if (x < 0) y = x >>> 3;
      end
      MODE_HSIG: begin
        if (h < 0)          y = '0;
        else if (h > ONE_W) y = ONE_W;
        else                y = h;
      end
      default: y = x;
    endcase
    return y;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] quant_val(input wide_t y, input logic hsig,
                                                     input logic sgn);
    wide_t                 q;
    qwide_t                qh;
    logic [OUT_WIDTH-1:0]  r;
    q  = y >>> SH;
    qh = (qwide_t'(y) <<< OUT_WIDTH) >>> FRAC_BITS;
    if (hsig) begin
      // HSIG output is a pure unsigned fraction in [0, 1).
      r = (qh > UMAX_Q) ? UMAX_Q[OUT_WIDTH-1:0] : qh[OUT_WIDTH-1:0];
    end else if (sgn) begin
      if (q > SMAX)      r = SMAX[OUT_WIDTH-1:0];
      else if (q < SMIN) r = SMIN[OUT_WIDTH-1:0];
      else               r = q[OUT_WIDTH-1:0];
    end else begin
      if (q > UMAX)      r = UMAX[OUT_WIDTH-1:0];
      else if (q < 0)    r = '0;
      else               r = q[OUT_WIDTH-1:0];
    end
    return r;
  endfunction

`ifdef ACT_SAT_COUNT_EN
  function automatic logic quant_sat(input wide_t y, input logic hsig, input logic sgn);
    wide_t  q;
    qwide_t qh;
    logic   s;
    q  = y >>> SH;
    qh = (qwide_t'(y) <<< OUT_WIDTH) >>> FRAC_BITS;
    if (hsig)     s = (qh > UMAX_Q);
    else if (sgn) s = (q > SMAX) || (q < SMIN);
    else          s = (q > UMAX) || (q < 0);
    return s;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic                              advance;

  logic                              s1_valid_q;
  logic [MATRIX_WIDTH*IN_WIDTH-1:0]  s1_data_q;
  logic [2:0]                        s1_mode_q;
  logic                              s1_signed_q;

  logic                              s2_valid_q;
  wide_t                             s2_y_q [MATRIX_WIDTH];
  wide_t                             s2_y_d [MATRIX_WIDTH];
  logic                              s2_hsig_q;
  logic                              s2_signed_q;

  logic                              s3_valid_q;
  logic [MATRIX_WIDTH*OUT_WIDTH-1:0] s3_data_q;
  logic [MATRIX_WIDTH*OUT_WIDTH-1:0] s3_data_d;

  logic                              out_valid_q;
  logic [MATRIX_WIDTH*OUT_WIDTH-1:0] out_data_q;

`ifdef ACT_SAT_COUNT_EN
  logic [MATRIX_WIDTH-1:0]           s3_sat_q;
  logic [MATRIX_WIDTH-1:0]           s3_sat_d;
`endif

  // The whole pipeline moves in lock-step; it only stalls while a finished
  // beat sits in the output register unclaimed.
  assign advance     = !out_valid_q || out_ready_i;
  assign in_ready_o  = advance;
  assign out_valid_o = out_valid_q;
  assign data_out_o  = out_data_q;

  always_comb begin
    s2_y_d = '{default: '0};
    for (int i = 0; i < MATRIX_WIDTH; i++) begin
      s2_y_d[i] = act_fn(extend(s1_data_q[i*IN_WIDTH +: IN_WIDTH], s1_signed_q), s1_mode_q);
    end
  end

  always_comb begin
    s3_data_d = '0;
    for (int i = 0; i < MATRIX_WIDTH; i++) begin
      s3_data_d[i*OUT_WIDTH +: OUT_WIDTH] = quant_val(s2_y_q[i], s2_hsig_q, s2_signed_q);
    end
  end

`ifdef ACT_SAT_COUNT_EN
  always_comb begin
    s3_sat_d = '0;
    for (int i = 0; i < MATRIX_WIDTH; i++) begin
      s3_sat_d[i] = quant_sat(s2_y_q[i], s2_hsig_q, s2_signed_q);
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_mode_q   <= MODE_NONE;
      s1_signed_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_y_q      <= '{default: '0};
      s2_hsig_q   <= 1'b0;
      s2_signed_q <= 1'b0;
      s3_valid_q  <= 1'b0;
      s3_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef ACT_SAT_COUNT_EN
      s3_sat_q    <= '0;
`endif
    end else if (advance) begin
      s1_valid_q  <= in_valid_i;
      s1_data_q   <= data_in_i;
      s1_mode_q   <= mode_i;
      s1_signed_q <= is_signed_i;
      s2_valid_q  <= s1_valid_q;
      s2_y_q      <= s2_y_d;
      s2_hsig_q   <= (s1_mode_q == MODE_HSIG);
      s2_signed_q <= s1_signed_q;
      s3_valid_q  <= s2_valid_q;
      s3_data_q   <= s3_data_d;
      out_valid_q <= s3_valid_q;
      out_data_q  <= s3_data_q;
`ifdef ACT_SAT_COUNT_EN
      s3_sat_q    <= s3_sat_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Saturation counter
  // ---------------------------------------------------------------------------
`ifdef ACT_SAT_COUNT_EN
  logic [31:0] sat_count_q;
  logic [31:0] sat_count_d;
  logic [32:0] sat_sum;

  always_comb begin
    sat_sum = {1'b0, sat_count_q};
    for (int i = 0; i < MATRIX_WIDTH; i++) begin
      sat_sum = sat_sum + 33'(s3_sat_q[i]);
    end
    sat_count_d = sat_count_q;
    if (sat_clear_i) begin
      sat_count_d = '0;
    end else if (advance && s3_valid_q) begin
      sat_count_d = sat_sum[32] ? '1 : sat_sum[31:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sat_count_q <= '0;
    else       sat_count_q <= sat_count_d;
  end

  assign sat_count_o = sat_count_q;
`endif

endmodule
